// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The FSM state type, the digit-adjust constants, and the saturation nibble live here.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;
  localparam logic [3:0] BCD_NINE   = 4'd9;

  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: digits of 5 or more get +3 (mod 16),
// so that the following left shift carries correctly into the next decade.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i + ADJ_ADD) : digit_i;

endmodule

// File: rtl/seq_binary_bcd.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Handshake: start is accepted only while ready; done pulses for one cycle when bcd_out/overflow update.
module seq_binary_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output state_t                dbg_state
);

  localparam int BCD_W = bcd_width(DIGITS);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic               ovf_scr_q, ovf_scr_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   adj_w;
  logic [BCD_W-1:0]   sat_w;
  logic [BCD_W-1:0]   scr_shift_w;
  logic [BIN_W-1:0]   bin_shift_w;
  logic               ovf_shift_w;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit_i (scr_q[4*k +: 4]),
      .digit_o (adj_w[4*k +: 4])
    );
    assign sat_w[4*k +: 4] = BCD_NINE;
  end

  // A 1 shifted out of the top digit means the value needs more than DIGITS digits.
  assign scr_shift_w = {adj_w[BCD_W-2:0], bin_q[BIN_W-1]};
  assign bin_shift_w = bin_q << 1;
  assign ovf_shift_w = ovf_scr_q | adj_w[BCD_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      scr_q     <= '0;
      ovf_scr_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      scr_q     <= scr_d;
      ovf_scr_q <= ovf_scr_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    scr_d     = scr_q;
    ovf_scr_d = ovf_scr_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          scr_d     = '0;
          ovf_scr_d = 1'b0;
          cnt_d     = CNT_LOAD;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bin_d     = bin_shift_w;
        scr_d     = scr_shift_w;
        ovf_scr_d = ovf_shift_w;
        cnt_d     = cnt_q - CNT_LAST;
        // Final shift: publish the result straight from the shifted value.
        if (cnt_q == CNT_LAST) begin
          bcd_d   = ovf_shift_w ? sat_w : scr_shift_w;
          ovf_d   = ovf_shift_w;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
  assign bcd_out   = bcd_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_binary_bcd.sv
// Bench for seq_binary_bcd: three configurations (8/3, 8/2, 4/2) driven with random
// and directed values, checked against a decimal reference model.
module tb_seq_binary_bcd;
  import bcd_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Config A: BIN_W=8, DIGITS=3
  logic a_start, a_ready, a_busy, a_done, a_ovf;
  logic [7:0] a_bin;
  logic [11:0] a_bcd;
  state_t a_state;
  // Config B: BIN_W=8, DIGITS=2
  logic b_start, b_ready, b_busy, b_done, b_ovf;
  logic [7:0] b_bin;
  logic [7:0] b_bcd;
  state_t b_state;
  // Config C: BIN_W=4, DIGITS=2
  logic c_start, c_ready, c_busy, c_done, c_ovf;
  logic [3:0] c_bin;
  logic [7:0] c_bcd;
  state_t c_state;

  seq_binary_bcd #(.BIN_W(8), .DIGITS(3)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .bin_in(a_bin), .ready(a_ready),
    .busy(a_busy), .done(a_done), .bcd_out(a_bcd), .overflow(a_ovf), .dbg_state(a_state));
  seq_binary_bcd #(.BIN_W(8), .DIGITS(2)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .bin_in(b_bin), .ready(b_ready),
    .busy(b_busy), .done(b_done), .bcd_out(b_bcd), .overflow(b_ovf), .dbg_state(b_state));
  seq_binary_bcd #(.BIN_W(4), .DIGITS(2)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .bin_in(c_bin), .ready(c_ready),
    .busy(c_busy), .done(c_done), .bcd_out(c_bcd), .overflow(c_ovf), .dbg_state(c_state));

  // Reference: {overflow, bcd} from plain decimal arithmetic.
  function automatic logic [16:0] ref_conv(input int v, input int digits);
    int lim = 1;
    int r = v;
    logic [15:0] b = '0;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int k = 0; k < digits; k++) b[4*k +: 4] = 4'd9;
      return {1'b1, b};
    end
    for (int k = 0; k < digits; k++) begin
      b[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {1'b0, b};
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      0: return a_done;
      1: return b_done;
      default: return c_done;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      0: return a_busy;
      1: return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic logic get_ready(input int w);
    case (w)
      0: return a_ready;
      1: return b_ready;
      default: return c_ready;
    endcase
  endfunction

  function automatic logic get_ovf(input int w);
    case (w)
      0: return a_ovf;
      1: return b_ovf;
      default: return c_ovf;
    endcase
  endfunction

  function automatic logic [15:0] get_bcd(input int w);
    case (w)
      0: return {4'b0, a_bcd};
      1: return {8'b0, b_bcd};
      default: return {8'b0, c_bcd};
    endcase
  endfunction

  task automatic drive_start(input int w, input logic s, input int v);
    case (w)
      0: begin a_start = s; a_bin = v[7:0]; end
      1: begin b_start = s; b_bin = v[7:0]; end
      default: begin c_start = s; c_bin = v[3:0]; end
    endcase
  endtask

  // Driver: one conversion; returns observations at the negedge where done is seen.
  // lat counts posedges after the accepting edge; bin_in is scrambled while shifting.
  task automatic convert(input int w, input int v, output logic [15:0] bcd, output logic ovf,
                         output int lat, output int busy_n, output logic rdy, output bit timeout);
    @(negedge clk);
    drive_start(w, 1'b1, v);
    @(negedge clk);
    drive_start(w, 1'b0, int'($urandom));
    lat = 0;
    busy_n = 0;
    timeout = 1'b0;
    while (!get_done(w)) begin
      if (get_busy(w)) busy_n++;
      if (lat >= 40) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    bcd = get_bcd(w);
    ovf = get_ovf(w);
    rdy = get_ready(w);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", a_ready); else pass_cnt++;
    total_cnt++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", a_busy); else pass_cnt++;
    total_cnt++; if (a_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", a_done); else pass_cnt++;
    total_cnt++; if (a_bcd !== 12'h000) $display("FAIL reset_bcd: got %h expected 000", a_bcd); else pass_cnt++;
    total_cnt++; if (a_ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", a_ovf); else pass_cnt++;
    total_cnt++; if (a_state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", a_state, IDLE); else pass_cnt++;
    total_cnt++; if ({b_bcd, c_bcd} !== 16'h0) $display("FAIL reset_bc_bcd: got %h expected 0000", {b_bcd, c_bcd}); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_base();
    logic [15:0] bcd; logic ovf, rdy; int lat, busy_n; bit to;
    convert(0, 255, bcd, ovf, lat, busy_n, rdy, to);
    total_cnt++; if (to) $display("FAIL base_timeout: got timeout expected done"); else pass_cnt++;
    total_cnt++; if (bcd[11:0] !== 12'h255) $display("FAIL base_bcd: got %h expected 255", bcd[11:0]); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL base_ovf: got %b expected 0", ovf); else pass_cnt++;
    total_cnt++; if (lat != 8) $display("FAIL base_latency: got %0d expected 8", lat); else pass_cnt++;
    total_cnt++; if (busy_n != 8) $display("FAIL base_busy_cycles: got %0d expected 8", busy_n); else pass_cnt++;
    total_cnt++; if (rdy !== 1'b1) $display("FAIL base_ready_at_done: got %b expected 1", rdy); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_done !== 1'b0) $display("FAIL base_done_pulse: got %b expected 0", a_done); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      a_bin = 8'($urandom);
      @(negedge clk);
    end
    total_cnt++; if (a_bcd !== 12'h255) $display("FAIL base_hold: got %h expected 255", a_bcd); else pass_cnt++;
  endtask

  task automatic test_boundaries();
    int vals[5] = '{0, 9, 10, 99, 100};
    logic [11:0] exps[5] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100};
    logic [15:0] bcd; logic ovf, rdy; int lat, busy_n; bit to;
    for (int i = 0; i < 5; i++) begin
      convert(0, vals[i], bcd, ovf, lat, busy_n, rdy, to);
      total_cnt++;
      if (to || bcd[11:0] !== exps[i] || ovf !== 1'b0)
        $display("FAIL boundary_%0d: got %h ovf %b to %0d expected %h ovf 0", vals[i], bcd[11:0], ovf, to, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [15:0] bcd; logic ovf, rdy; int lat, busy_n; bit to; int v; logic [16:0] exp_v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom_range(0, 255);
      exp_v = ref_conv(v, 3);
      convert(0, v, bcd, ovf, lat, busy_n, rdy, to);
      total_cnt++;
      if (to || bcd[11:0] !== exp_v[11:0] || ovf !== exp_v[16] || lat != 8)
        $display("FAIL random_%0d: got %h ovf %b lat %0d expected %h ovf %b lat 8", v, bcd[11:0], ovf, lat, exp_v[11:0], exp_v[16]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bcd; logic ovf, rdy; int lat, busy_n; bit to; int v; logic [16:0] exp_v;
    int dones, done_at; logic [11:0] got;
    v = $urandom_range(0, 255);
    exp_v = ref_conv(v, 3);
    convert(0, v, bcd, ovf, lat, busy_n, rdy, to);
    total_cnt++; if (to || bcd[11:0] !== exp_v[11:0]) $display("FAIL b2b_first: got %h expected %h", bcd[11:0], exp_v[11:0]); else pass_cnt++;
    a_start = 1'b1; a_bin = 8'd42;
    @(negedge clk);
    total_cnt++; if (a_busy !== 1'b1) $display("FAIL b2b_accept: got busy %b expected 1", a_busy); else pass_cnt++;
    dones = 0; done_at = -1; got = '0;
    for (int l = 0; l < 20; l++) begin
      a_start = (l == 3);
      a_bin = (l == 3) ? 8'd7 : 8'($urandom);
      if (a_done) begin
        dones++;
        if (done_at < 0) begin done_at = l; got = a_bcd; end
      end
      @(negedge clk);
    end
    a_start = 1'b0;
    total_cnt++; if (dones != 1) $display("FAIL b2b_done_count: got %0d expected 1", dones); else pass_cnt++;
    total_cnt++; if (done_at != 8) $display("FAIL b2b_latency: got %0d expected 8", done_at); else pass_cnt++;
    total_cnt++; if (got !== 12'h042) $display("FAIL b2b_bcd: got %h expected 042", got); else pass_cnt++;
    total_cnt++; if (a_bcd !== 12'h042) $display("FAIL b2b_ignored_start: got %h expected 042", a_bcd); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int vals[5] = '{200, 57, 99, 100, 255};
    logic [7:0] exps[5] = '{8'h99, 8'h57, 8'h99, 8'h99, 8'h99};
    logic ovfs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] bcd; logic ovf, rdy; int lat, busy_n; bit to; int v; logic [16:0] exp_v;
    for (int i = 0; i < 5; i++) begin
      convert(1, vals[i], bcd, ovf, lat, busy_n, rdy, to);
      total_cnt++;
      if (to || bcd[7:0] !== exps[i] || ovf !== ovfs[i] || lat != 8)
        $display("FAIL ovf_dir_%0d: got %h ovf %b lat %0d expected %h ovf %b lat 8", vals[i], bcd[7:0], ovf, lat, exps[i], ovfs[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      v = $urandom_range(0, 255);
      exp_v = ref_conv(v, 2);
      convert(1, v, bcd, ovf, lat, busy_n, rdy, to);
      total_cnt++;
      if (to || bcd[7:0] !== exp_v[7:0] || ovf !== exp_v[16])
        $display("FAIL ovf_rand_%0d: got %h ovf %b expected %h ovf %b", v, bcd[7:0], ovf, exp_v[7:0], exp_v[16]);
      else pass_cnt++;
    end
  endtask

  task automatic test_small();
    logic [15:0] bcd; logic ovf, rdy; int lat, busy_n; bit to; logic [16:0] exp_v;
    convert(2, 15, bcd, ovf, lat, busy_n, rdy, to);
    total_cnt++; if (to || bcd[7:0] !== 8'h15 || ovf !== 1'b0) $display("FAIL small_15: got %h ovf %b expected 15 ovf 0", bcd[7:0], ovf); else pass_cnt++;
    total_cnt++; if (lat != 4 || busy_n != 4) $display("FAIL small_latency: got lat %0d busy %0d expected 4 4", lat, busy_n); else pass_cnt++;
    for (int v = 0; v < 16; v++) begin
      exp_v = ref_conv(v, 2);
      convert(2, v, bcd, ovf, lat, busy_n, rdy, to);
      total_cnt++;
      if (to || bcd[7:0] !== exp_v[7:0] || ovf !== exp_v[16])
        $display("FAIL small_sweep_%0d: got %h ovf %b expected %h ovf %b", v, bcd[7:0], ovf, exp_v[7:0], exp_v[16]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] bcd; logic ovf, rdy; int lat, busy_n; bit to; int dones;
    @(negedge clk);
    a_start = 1'b1; a_bin = 8'd255;
    @(negedge clk);
    a_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++; if (a_ready !== 1'b1 || a_busy !== 1'b0) $display("FAIL midrst_ready: got ready %b busy %b expected 1 0", a_ready, a_busy); else pass_cnt++;
    total_cnt++; if (a_bcd !== 12'h000 || a_ovf !== 1'b0) $display("FAIL midrst_bcd: got %h ovf %b expected 000 0", a_bcd, a_ovf); else pass_cnt++;
    total_cnt++; if (a_done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", a_done); else pass_cnt++;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (a_done) dones++;
      @(negedge clk);
    end
    total_cnt++; if (dones != 0) $display("FAIL midrst_no_done: got %0d expected 0", dones); else pass_cnt++;
    convert(0, 128, bcd, ovf, lat, busy_n, rdy, to);
    total_cnt++; if (to || bcd[11:0] !== 12'h128 || ovf !== 1'b0) $display("FAIL midrst_fresh: got %h ovf %b expected 128 0", bcd[11:0], ovf); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_bin = '0;
    b_start = 1'b0; b_bin = '0;
    c_start = 1'b0; c_bin = '0;
    test_reset();
    test_base();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_overflow();
    test_small();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
